bit_deserializer: RTL and testbench
===================================

Name: bit_deserializer

Overview:
- Serial-to-parallel converter: samples one serial bit per clock while enabled and shifts it into a WIDTH-bit register.
- The register is visible on out_data at all times.
- A one-cycle out_valid strobe flags each completed WIDTH-bit word.
- Sits behind a serial receive/front-end stage; feeds word-oriented downstream logic.

Parameters:
- WIDTH, 8, number of bits per parallel word (>=2).
- MSB_FIRST, 1, 1: shift left, new bit enters bit 0, first bit received ends in bit WIDTH-1; 0: shift right, new bit enters bit WIDTH-1.

Ports:
- in_clock  input  1  single system clock; all state updates on rising edge.
- in_reset_n  input  1  synchronous, active-low reset.
- in_bit  input  1  serial data bit, sampled on rising edge when in_enable=1.
- in_enable  input  1  shift-enable; 1 = sample in_bit this cycle, 0 = hold.
- out_data  output  WIDTH  current shift-register contents (registered).
- out_valid  output  1  one-cycle pulse: a full WIDTH-bit word has just been completed.
- out_count  output  clog2(WIDTH+1)  bits collected in the current word, 0..WIDTH-1.

Behaviour:
- Reset (in_reset_n=0 at a rising edge): out_data=0, out_count=0, out_valid=0. Reset overrides in_enable.
- Rising edge, in_enable=1, MSB_FIRST=1: out_data <= {out_data[WIDTH-2:0], in_bit}.
- Rising edge, in_enable=1, MSB_FIRST=0: out_data <= {in_bit, out_data[WIDTH-1:1]}.
- Rising edge, in_enable=0: out_data and out_count hold; out_valid <= 0.
- Latency: a bit sampled at edge N is visible in out_data immediately after edge N (one register stage). No combinational path from inputs to outputs.
- Counter:
  - On each enabled edge, out_count increments.
  - When an enabled edge takes out_count from WIDTH-1 to the wrap point, out_count <= 0 and out_valid <= 1 for exactly that following cycle.
  - out_data then holds the completed word.
- Continuous enable: words are back-to-back. out_valid pulses every WIDTH enabled cycles. The shift register is not cleared between words; old bits shift out naturally.
- Gaps in enable: the partial word and out_count are retained across any number of disabled cycles, and accumulation resumes where it stopped.
- out_valid is never asserted on a disabled cycle, or on the cycle after reset.
- Mid-operation reset: the partial word is discarded, out_data=0, and counting restarts from 0.
- in_bit is ignored entirely while in_enable=0.

Decomposition:
- Shared package: none required; optional COUNT_W = $clog2(WIDTH+1) helper constant if the codebase has a common utility package.
- Single module; no sub-module needed. Shift register and bit counter in one clocked always block.

Test Plan:
- Reset: hold in_reset_n=0 for 2 cycles with in_enable=1, in_bit=1 -> out_data=0x00, out_count=0, out_valid=0.
- Shift basics (WIDTH=8, MSB_FIRST=1): enable=1 with bits 1,0 on consecutive edges -> out_data 0x01 then 0x02, out_count 1 then 2, out_valid=0.
- Hold: after the above, enable=0 for 3 cycles with in_bit=1 -> out_data stays 0x02, out_count stays 2.
- Resume: re-enable with bits 1,0,0 -> out_data 0x05, 0x0A, 0x14; count 3, 4, 5.
- Full word: enable=1 and shift 0xA5 MSB-first over 8 cycles -> out_data=0xA5 and out_valid=1 for exactly one cycle, then count=0. A continued 8 bits of 0x3C -> out_data=0x3C, second out_valid pulse exactly 8 enabled cycles later.
- LSB-first and reset mid-word: MSB_FIRST=0, shift 0xA5 LSB-first -> out_data=0xA5 with out_valid pulse. Then shift 3 bits and pulse in_reset_n low one cycle -> out_data=0, out_count=0; the next 8 bits form a clean word.

Source files
------------

// File: rtl/bit_deserializer_pkg.sv
// Shared helpers for the serial-to-parallel deserializer.
// Sizes the bit counter so it can hold every value from 0 to WIDTH.
package bit_deserializer_pkg;

    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/bit_deserializer.sv
// Serial-to-parallel converter: shifts one bit per enabled clock into a WIDTH-bit
// register and pulses out_valid for one cycle after each completed word.
module bit_deserializer
    import bit_deserializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    localparam int COUNT_W  = count_width(WIDTH)
) (
    input  logic               in_clock,
    input  logic               in_reset_n,
    input  logic               in_bit,
    input  logic               in_enable,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    output logic [COUNT_W-1:0] out_count
);

    logic [WIDTH-1:0]   data_q,  data_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               valid_q, valid_d;
    logic               count_last;

    assign count_last = (count_q == COUNT_W'(WIDTH - 1));

    // NOTE: every next-state signal gets its hold value first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        data_d  = data_q;
        count_d = count_q;
        valid_d = 1'b0;
        if (in_enable) begin
            if (MSB_FIRST) begin
                data_d = {data_q[WIDTH-2:0], in_bit};
            end else begin
                data_d = {in_bit, data_q[WIDTH-1:1]};
            end
            if (count_last) begin
                count_d = '0;
                valid_d = 1'b1;
            end else begin
                count_d = count_q + COUNT_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
    always_ff @(posedge in_clock) begin
        if (!in_reset_n) begin
            data_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_count = count_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_bit_deserializer.sv
// Directed bench for bit_deserializer: table-driven MSB-first vectors, then
// hand-written LSB-first, mid-word reset and back-to-back sequences.
module tb_bit_deserializer;

    logic       clk = 1'b0;
    logic       m_rst_n, m_en, m_bit;
    logic       l_rst_n, l_en, l_bit;
    logic [7:0] m_data, l_data;
    logic       m_valid, l_valid;
    logic [3:0] m_count, l_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bit_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .in_clock   (clk),
        .in_reset_n (m_rst_n),
        .in_bit     (m_bit),
        .in_enable  (m_en),
        .out_data   (m_data),
        .out_valid  (m_valid),
        .out_count  (m_count)
    );

    bit_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .in_clock   (clk),
        .in_reset_n (l_rst_n),
        .in_bit     (l_bit),
        .in_enable  (l_en),
        .out_data   (l_data),
        .out_valid  (l_valid),
        .out_count  (l_count)
    );

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       b;
        logic [7:0] data;
        logic [3:0] count;
        logic       valid;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic b,
                       input logic [7:0] d, input logic [3:0] c, input logic v);
        vec_t t;
        t.rst_n = r; t.en = e; t.b = b; t.data = d; t.count = c; t.valid = v;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic msb_step(input logic r, input logic e, input logic b);
        @(negedge clk);
        m_rst_n = r; m_en = e; m_bit = b;
        @(posedge clk);
        #1;
    endtask

    task automatic lsb_step(input string name, input logic r, input logic e, input logic b,
                            input logic [7:0] d, input logic [3:0] c, input logic v);
        @(negedge clk);
        l_rst_n = r; l_en = e; l_bit = b;
        @(posedge clk);
        #1;
        check({name, " data"},  32'(l_data),  32'(d));
        check({name, " count"}, 32'(l_count), 32'(c));
        check({name, " valid"}, 32'(l_valid), 32'(v));
    endtask

    initial begin
        int pulses;
        int misplaced;
        logic [7:0] w;

        m_rst_n = 1'b0; m_en = 1'b1; m_bit = 1'b1;
        l_rst_n = 1'b0; l_en = 1'b1; l_bit = 1'b1;

        // reset held two cycles with enable and data high
        add(0, 1, 1, 8'h00, 4'd0, 0);
        add(0, 1, 1, 8'h00, 4'd0, 0);
        // shift basics
        add(1, 1, 1, 8'h01, 4'd1, 0);
        add(1, 1, 0, 8'h02, 4'd2, 0);
        // hold with in_bit high
        add(1, 0, 1, 8'h02, 4'd2, 0);
        add(1, 0, 1, 8'h02, 4'd2, 0);
        add(1, 0, 1, 8'h02, 4'd2, 0);
        // resume
        add(1, 1, 1, 8'h05, 4'd3, 0);
        add(1, 1, 0, 8'h0A, 4'd4, 0);
        add(1, 1, 0, 8'h14, 4'd5, 0);
        // realign, then 0xA5 MSB-first
        add(0, 1, 1, 8'h00, 4'd0, 0);
        add(1, 1, 1, 8'h01, 4'd1, 0);
        add(1, 1, 0, 8'h02, 4'd2, 0);
        add(1, 1, 1, 8'h05, 4'd3, 0);
        add(1, 1, 0, 8'h0A, 4'd4, 0);
        add(1, 1, 0, 8'h14, 4'd5, 0);
        add(1, 1, 1, 8'h29, 4'd6, 0);
        add(1, 1, 0, 8'h52, 4'd7, 0);
        add(1, 1, 1, 8'hA5, 4'd0, 1);
        // 0x3C back-to-back, old bits shift out
        add(1, 1, 0, 8'h4A, 4'd1, 0);
        add(1, 1, 0, 8'h94, 4'd2, 0);
        add(1, 1, 1, 8'h29, 4'd3, 0);
        add(1, 1, 1, 8'h53, 4'd4, 0);
        add(1, 1, 1, 8'hA7, 4'd5, 0);
        add(1, 1, 1, 8'h4F, 4'd6, 0);
        add(1, 1, 0, 8'h9E, 4'd7, 0);
        add(1, 1, 0, 8'h3C, 4'd0, 1);
        // disabled cycle right after a completed word: no pulse
        add(1, 0, 1, 8'h3C, 4'd0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            msb_step(vecs[i].rst_n, vecs[i].en, vecs[i].b);
            check($sformatf("msb[%0d] data", i),  32'(m_data),  32'(vecs[i].data));
            check($sformatf("msb[%0d] count", i), 32'(m_count), 32'(vecs[i].count));
            check($sformatf("msb[%0d] valid", i), 32'(m_valid), 32'(vecs[i].valid));
        end

        // back-to-back words: 24 enabled cycles give pulses after cycles 8, 16, 24
        pulses = 0;
        misplaced = 0;
        for (int i = 0; i < 24; i++) begin
            msb_step(1'b1, 1'b1, 1'(i % 3));
            if (m_valid) begin
                pulses++;
                if (i % 8 != 7) misplaced++;
            end
        end
        check("msb b2b pulse count", 32'(pulses), 32'd3);
        check("msb b2b misplaced pulses", 32'(misplaced), 32'd0);
        m_en = 1'b0;

        // LSB-first: reset, then 0xA5
        lsb_step("lsb rst0", 0, 1, 1, 8'h00, 4'd0, 0);
        lsb_step("lsb rst1", 0, 1, 1, 8'h00, 4'd0, 0);
        w = 8'hA5;
        lsb_step("lsb a5 b0", 1, 1, w[0], 8'h80, 4'd1, 0);
        lsb_step("lsb a5 b1", 1, 1, w[1], 8'h40, 4'd2, 0);
        lsb_step("lsb a5 b2", 1, 1, w[2], 8'hA0, 4'd3, 0);
        lsb_step("lsb a5 b3", 1, 1, w[3], 8'h50, 4'd4, 0);
        lsb_step("lsb a5 b4", 1, 1, w[4], 8'h28, 4'd5, 0);
        lsb_step("lsb a5 b5", 1, 1, w[5], 8'h94, 4'd6, 0);
        lsb_step("lsb a5 b6", 1, 1, w[6], 8'h4A, 4'd7, 0);
        lsb_step("lsb a5 b7", 1, 1, w[7], 8'hA5, 4'd0, 1);
        // partial word then mid-word reset
        lsb_step("lsb part0", 1, 1, 1, 8'hD2, 4'd1, 0);
        lsb_step("lsb part1", 1, 1, 1, 8'hE9, 4'd2, 0);
        lsb_step("lsb part2", 1, 1, 1, 8'hF4, 4'd3, 0);
        lsb_step("lsb midrst", 0, 1, 1, 8'h00, 4'd0, 0);
        // clean 0x3C word with an enable gap in the middle
        w = 8'h3C;
        lsb_step("lsb 3c b0", 1, 1, w[0], 8'h00, 4'd1, 0);
        lsb_step("lsb 3c b1", 1, 1, w[1], 8'h00, 4'd2, 0);
        lsb_step("lsb 3c b2", 1, 1, w[2], 8'h80, 4'd3, 0);
        lsb_step("lsb 3c b3", 1, 1, w[3], 8'hC0, 4'd4, 0);
        lsb_step("lsb gap0", 1, 0, 1, 8'hC0, 4'd4, 0);
        lsb_step("lsb gap1", 1, 0, 1, 8'hC0, 4'd4, 0);
        lsb_step("lsb 3c b4", 1, 1, w[4], 8'hE0, 4'd5, 0);
        lsb_step("lsb 3c b5", 1, 1, w[5], 8'hF0, 4'd6, 0);
        lsb_step("lsb 3c b6", 1, 1, w[6], 8'h78, 4'd7, 0);
        lsb_step("lsb 3c b7", 1, 1, w[7], 8'h3C, 4'd0, 1);
        lsb_step("lsb after", 1, 0, 0, 8'h3C, 4'd0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
